// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parameterised UART receiver with majority-vote bit sampling,
//               optional parity, 1/2 stop bits and a one-deep holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int CLK_FREQ     = 10_000_000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_serial_data,
    output logic [PAYLOAD_BITS-1:0] o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_parity_err,
    output logic                    o_frame_err,
    output logic                    o_overrun,
    output logic                    o_busy
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
    localparam int c_HALF         = c_CLKS_PER_BIT / 2;
    localparam int c_CNT_W        = (c_CLKS_PER_BIT > 2) ? $clog2(c_CLKS_PER_BIT) : 2;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_S0   = c_CNT_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_S1   = c_CNT_W'(c_HALF);
    localparam logic [c_CNT_W-1:0] c_CNT_DEC  = c_CNT_W'(c_HALF + 1);
    localparam logic [3:0]         c_BIT_LAST = 4'(PAYLOAD_BITS - 1);
    localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    if (c_CLKS_PER_BIT < 4) begin : g_bad_rate
        $error("uart_rx_param: CLK_FREQ/BIT_RATE must be at least 4");
    end
    if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 9) begin : g_bad_payload
        $error("uart_rx_param: PAYLOAD_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    logic                    r_sync_meta;
    logic                    r_sync;
    logic [2:0]              r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [3:0]              r_bit_idx;
    logic                    r_stop_idx;
    logic                    r_samp0;
    logic                    r_samp1;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    r_par_err;
    logic                    r_frame_err;
    logic [PAYLOAD_BITS-1:0] r_data;
    logic                    r_valid;
    logic                    r_perr_out;
    logic                    r_ferr_out;
    logic                    r_overrun;

    logic w_maj;
    logic w_wrap;
    logic w_decide;
    logic w_done;
    logic w_accept;
    logic w_load;
    logic w_drop;
    logic w_par_xor;

    assign w_maj     = (r_samp0 & r_samp1) | (r_samp0 & r_sync) | (r_samp1 & r_sync);
    assign w_wrap    = (r_cnt == c_CNT_LAST);
    assign w_decide  = (r_cnt == c_CNT_DEC);
    assign w_par_xor = (^r_shift) ^ w_maj;
    assign w_done    = (r_state == c_ST_STOP) && w_decide && (r_stop_idx == c_STOP_LAST);
    assign w_accept  = r_valid && i_ready;
    // A frame lands if the register is empty or is being emptied this very cycle.
    assign w_load    = w_done && (!r_valid || i_ready);
    assign w_drop    = w_done && r_valid && !i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_meta <= 1'b1;
            r_sync      <= 1'b1;
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_samp0     <= 1'b1;
            r_samp1     <= 1'b1;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync_meta <= i_serial_data;
            r_sync      <= r_sync_meta;

            if (r_cnt == c_CNT_S0) r_samp0 <= r_sync;
            if (r_cnt == c_CNT_S1) r_samp1 <= r_sync;

            if (r_state == c_ST_IDLE || w_wrap) r_cnt <= '0;
            else                                r_cnt <= r_cnt + 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    if (!r_sync) begin
                        r_state     <= c_ST_START;
                        r_bit_idx   <= '0;
                        r_stop_idx  <= 1'b0;
                        r_par_err   <= 1'b0;
                        r_frame_err <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_decide && w_maj) r_state <= c_ST_IDLE;
                    else if (w_wrap)       r_state <= c_ST_DATA;
                end
                c_ST_DATA: begin
                    if (w_decide) r_shift <= {w_maj, r_shift[PAYLOAD_BITS-1:1]};
                    if (w_wrap) begin
                        if (r_bit_idx == c_BIT_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY != 0) ? c_ST_PARITY : c_ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_decide) r_par_err <= (PARITY == 1) ? w_par_xor : ~w_par_xor;
                    if (w_wrap)   r_state   <= c_ST_STOP;
                end
                c_ST_STOP: begin
                    if (w_decide) begin
                        if (!w_maj) r_frame_err <= 1'b1;
                        if (r_stop_idx == c_STOP_LAST) r_state <= c_ST_IDLE;
                    end else if (w_wrap) begin
                        r_stop_idx <= 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_load) begin
                r_data     <= r_shift;
                r_perr_out <= r_par_err;
                r_ferr_out <= r_frame_err | ~w_maj;
                r_valid    <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end

            if (w_drop)        r_overrun <= 1'b1;
            else if (w_accept) r_overrun <= 1'b0;
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_parity_err = r_perr_out;
    assign o_frame_err  = r_ferr_out;
    assign o_overrun    = r_overrun;
    assign o_busy       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Directed bench for uart_rx_param; A = no parity/1 stop,
//               B = even parity/2 stops, both at 10 clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int c_CPB = 10;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       line_a  = 1'b1;
    logic       line_b  = 1'b1;
    logic       ready_a = 1'b1;
    logic       ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
    logic       ovr_a, ovr_b, busy_a, busy_b;

    int         n_checks = 0;
    int         n_errors = 0;
    int         acc_a = 0, acc_b = 0;
    int         base_a, base_b;
    logic [7:0] cap_data_a, cap_data_b;
    logic       cap_perr_a, cap_perr_b, cap_ferr_a, cap_ferr_b;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ(10_000_000), .BIT_RATE(1_000_000), .PAYLOAD_BITS(8),
        .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .reset(reset), .i_serial_data(line_a), .o_data(data_a),
        .o_valid(valid_a), .i_ready(ready_a), .o_parity_err(perr_a),
        .o_frame_err(ferr_a), .o_overrun(ovr_a), .o_busy(busy_a)
    );

    uart_rx_param #(
        .CLK_FREQ(10_000_000), .BIT_RATE(1_000_000), .PAYLOAD_BITS(8),
        .PARITY(1), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .reset(reset), .i_serial_data(line_b), .o_data(data_b),
        .o_valid(valid_b), .i_ready(ready_b), .o_parity_err(perr_b),
        .o_frame_err(ferr_b), .o_overrun(ovr_b), .o_busy(busy_b)
    );

    // Record every accepted frame, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid_a && ready_a) begin
            acc_a      <= acc_a + 1;
            cap_data_a <= data_a;
            cap_perr_a <= perr_a;
            cap_ferr_a <= ferr_a;
        end
        if (valid_b && ready_b) begin
            acc_b      <= acc_b + 1;
            cap_data_b <= data_b;
            cap_perr_b <= perr_b;
            cap_ferr_b <= ferr_b;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) line_b = v;
        else     line_a = v;
    endtask

    // Bits go out LSB first; bit 'glitch' is inverted for one cycle at count HALF.
    task automatic send_bits(input bit sel, input logic [15:0] bits, input int n, input int glitch);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < c_CPB; c++) begin
                drive(sel, (i == glitch && c == 6) ? ~bits[i] : bits[i]);
                tick(1);
            end
        end
    endtask

    task automatic frame_a(input logic [7:0] d, input logic stop);
        send_bits(1'b0, {6'b0, stop, d, 1'b0}, 10, -1);
    endtask

    task automatic frame_b(input logic [7:0] d, input logic par, input logic s1, input logic s2);
        send_bits(1'b1, {4'b0, s2, s1, par, d, 1'b0}, 12, -1);
    endtask

    initial begin
        tick(3);
        chk8("rst_data_a", data_a, 8'h00);
        chk1("rst_valid_a", valid_a, 1'b0);
        chk1("rst_perr_a", perr_a, 1'b0);
        chk1("rst_ferr_a", ferr_a, 1'b0);
        chk1("rst_ovr_a", ovr_a, 1'b0);
        chk1("rst_busy_a", busy_a, 1'b0);
        chk8("rst_data_b", data_b, 8'h00);
        chk1("rst_valid_b", valid_b, 1'b0);
        chk1("rst_ovr_b", ovr_b, 1'b0);
        chk1("rst_busy_b", busy_b, 1'b0);
        reset = 1'b0;
        tick(5);

        // Plain frame, consumer always ready
        base_a = acc_a;
        frame_a(8'hA5, 1'b1);
        tick(5);
        chki("a5_pulses", acc_a - base_a, 1);
        chk8("a5_data", cap_data_a, 8'hA5);
        chk1("a5_perr", cap_perr_a, 1'b0);
        chk1("a5_ferr", cap_ferr_a, 1'b0);
        chk1("a5_valid_low", valid_a, 1'b0);
        chk1("a5_ovr", ovr_a, 1'b0);

        // Even parity: 0x03 has two ones, so parity bit 1 is wrong
        base_b = acc_b;
        frame_b(8'h03, 1'b1, 1'b1, 1'b1);
        tick(5);
        chki("par1_pulses", acc_b - base_b, 1);
        chk8("par1_data", cap_data_b, 8'h03);
        chk1("par1_perr", cap_perr_b, 1'b1);
        chk1("par1_ferr", cap_ferr_b, 1'b0);
        frame_b(8'h03, 1'b0, 1'b1, 1'b1);
        tick(5);
        chk8("par0_data", cap_data_b, 8'h03);
        chk1("par0_perr", cap_perr_b, 1'b0);

        // Framing errors
        base_a = acc_a;
        frame_a(8'h5A, 1'b0);
        drive(1'b0, 1'b1);
        tick(15);
        chki("fe_a_pulses", acc_a - base_a, 1);
        chk8("fe_a_data", cap_data_a, 8'h5A);
        chk1("fe_a_ferr", cap_ferr_a, 1'b1);
        chk1("fe_a_perr", cap_perr_a, 1'b0);
        frame_a(8'h0F, 1'b1);
        tick(5);
        chk8("clean_a_data", cap_data_a, 8'h0F);
        chk1("clean_a_ferr", cap_ferr_a, 1'b0);
        base_b = acc_b;
        frame_b(8'h5A, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1);
        tick(15);
        chki("fe_b_pulses", acc_b - base_b, 1);
        chk8("fe_b_data", cap_data_b, 8'h5A);
        chk1("fe_b_ferr", cap_ferr_b, 1'b1);
        chk1("fe_b_perr", cap_perr_b, 1'b0);

        // False start: three low cycles
        base_a = acc_a;
        drive(1'b0, 1'b0);
        tick(3);
        drive(1'b0, 1'b1);
        chk1("fs_busy_hi", busy_a, 1'b1);
        tick(c_CPB);
        chk1("fs_busy_lo", busy_a, 1'b0);
        chki("fs_no_valid", acc_a - base_a, 0);

        // One-cycle glitch on data bit 2 of 0xC3
        send_bits(1'b0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 3);
        tick(5);
        chki("gl_pulses", acc_a - base_a, 1);
        chk8("gl_data", cap_data_a, 8'hC3);

        // Overrun with a stalled consumer
        ready_a = 1'b0;
        frame_a(8'h11, 1'b1);
        frame_a(8'h22, 1'b1);
        tick(5);
        chk1("ov_valid", valid_a, 1'b1);
        chk8("ov_data", data_a, 8'h11);
        chk1("ov_flag", ovr_a, 1'b1);
        ready_a = 1'b1;
        tick(1);
        ready_a = 1'b0;
        chk1("ov_valid_clr", valid_a, 1'b0);
        chk1("ov_flag_clr", ovr_a, 1'b0);
        chk8("ov_data_hold", data_a, 8'h11);

        // Reset in the middle of DATA with a frame still held
        frame_a(8'h99, 1'b1);
        tick(5);
        chk1("pre_rst_valid", valid_a, 1'b1);
        send_bits(1'b0, {6'b0, 1'b1, 8'h77, 1'b0}, 4, -1);
        chk1("pre_rst_busy", busy_a, 1'b1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        drive(1'b0, 1'b1);
        chk8("mrst_data", data_a, 8'h00);
        chk1("mrst_valid", valid_a, 1'b0);
        chk1("mrst_perr", perr_a, 1'b0);
        chk1("mrst_ferr", ferr_a, 1'b0);
        chk1("mrst_ovr", ovr_a, 1'b0);
        chk1("mrst_busy", busy_a, 1'b0);
        ready_a = 1'b1;
        tick(20);
        base_a = acc_a;
        frame_a(8'h3C, 1'b1);
        tick(5);
        chki("post_rst_pulses", acc_a - base_a, 1);
        chk8("post_rst_data", cap_data_a, 8'h3C);
        chk1("post_rst_perr", cap_perr_a, 1'b0);
        chk1("post_rst_ferr", cap_ferr_a, 1'b0);
        chk1("post_rst_ovr", ovr_a, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
